// File: rtl/instruction_memory_sync.sv
// Clocked instruction store: one fetch at a time over valid/ready with configurable latency,
// plus a byte-enabled program-load port that is independent of the fetch FSM.
module instruction_memory_sync #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_instr,
  output logic                  resp_fault,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_wdata,
  input  logic [3:0]            prog_be
);

  localparam int unsigned         IdxW     = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH:0] Three    = (ADDR_WIDTH + 1)'(3);
  localparam logic [3:0]          CntInit  = 4'(LATENCY - 1);
  localparam logic [31:0]         NopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           instr_q;
  logic                  fault_q;
  logic                  load;

  logic [7:0] mem [DEPTH_BYTES];

  // Memory is not reset; contents default to zero.
  initial begin
    for (int i = 0; i < int'(DEPTH_BYTES); i++) mem[i] = 8'h00;
  end

  // In IDLE the fetch is captured on the accepting edge itself (LATENCY == 1).
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [IdxW-1:0]       fetch_idx;
  logic                  fetch_fault;
  logic [31:0]           fetch_word;

  assign fetch_addr  = (state_q == StIdle) ? req_addr : addr_q;
  assign fetch_idx   = fetch_addr[IdxW-1:0];
  // Extended by one bit so a near-top address cannot wrap into range.
  assign fetch_fault = (fetch_addr[1:0] != 2'b00) || (({1'b0, fetch_addr} + Three) >= DepthExt);
  assign fetch_word  = fetch_fault ? NopInstr :
                       {mem[fetch_idx + IdxW'(3)], mem[fetch_idx + IdxW'(2)],
                        mem[fetch_idx + IdxW'(1)], mem[fetch_idx]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (LATENCY <= 1) begin
            state_d = StResp;
            load    = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          load    = 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      instr_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      if (load) begin
        instr_q <= fetch_word;
        fault_q <= fetch_fault;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_instr = instr_q;
  assign resp_fault = fault_q;

  // Program port: word-aligned, lanes gated by prog_be, out-of-range words dropped.
  logic [ADDR_WIDTH-1:0] prog_base;
  logic [IdxW-1:0]       prog_idx;
  logic                  prog_ok;
  logic                  unused_prog_lsb;

  assign prog_base       = {prog_addr[ADDR_WIDTH-1:2], 2'b00};
  assign prog_idx        = prog_base[IdxW-1:0];
  assign prog_ok         = ({1'b0, prog_base} + Three) < DepthExt;
  assign unused_prog_lsb = ^prog_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst && prog_we && prog_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (prog_be[i]) mem[prog_idx + IdxW'(i)] <= prog_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench: four instances (LATENCY 1..4) share stimulus; each test observes one of them.
module tb_instruction_memory_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        resp_ready = 1'b0;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_wdata = '0;
  logic [3:0]  prog_be = '0;

  logic [3:0]  rr, rv, rf;
  logic [31:0] ri [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    instruction_memory_sync #(
      .ADDR_WIDTH (32),
      .DEPTH_BYTES(1024),
      .LATENCY    (g + 1),
      .INIT_FILE  ("")
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (rr[g]),
      .req_addr  (req_addr),
      .resp_valid(rv[g]),
      .resp_ready(resp_ready),
      .resp_instr(ri[g]),
      .resp_fault(rf[g]),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_wdata(prog_wdata),
      .prog_be   (prog_be)
    );
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d; prog_be = be;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Full fetch on instance idx; lat counts edges from acceptance to resp_valid seen high.
  task automatic fetch(input int idx, input logic [31:0] a, output logic [31:0] instr,
                       output logic fault, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a;
    n = 0;
    while (!rr[idx] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rv[idx] && lat < 20) begin @(posedge clk); #1; lat++; end
    instr = ri[idx];
    fault = rf[idx];
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rr[i] !== 1'b1 || rv[i] !== 1'b0 || ri[i] !== 32'h0 || rf[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got ready=%b valid=%b instr=%h fault=%b, want 1 0 0 0",
                 i, rr[i], rv[i], ri[i], rf[i]);
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] words [3] = '{32'h00100093, 32'h00200113, 32'h002081b3};
    logic [31:0] instr;
    logic        fault;
    int          lat;
    for (int i = 0; i < 3; i++) prog(addrs[i], words[i], 4'hF);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch(0, addrs[i], instr, fault, lat);
      checks++;
      if (instr !== words[i]) begin
        errors++;
        $display("FAIL fetch_instr@%h: got %h want %h", addrs[i], instr, words[i]);
      end
      checks++;
      if (fault !== 1'b0) begin
        errors++;
        $display("FAIL fetch_fault@%h: got %b want 0", addrs[i], fault);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL fetch_latency@%h: got %0d want 1", addrs[i], lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!rv[2] && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 3", n);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rv[2] !== 1'b1 || ri[2] !== 32'h00200113 || rr[2] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b instr=%h ready=%b want 1 00200113 0",
                 k, rv[2], ri[2], rr[2]);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (rv[2] !== 1'b0 || rr[2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ready=%b want 0 1", rv[2], rr[2]);
    end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4] = '{32'h2, 32'h3FC, 32'h400, 32'hFFFFFFFC};
    logic        exp_f [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_i [4] = '{32'h13, 32'h0, 32'h13, 32'h13};
    logic [31:0] instr;
    logic        fault;
    int          lat;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fetch(0, addrs[i], instr, fault, lat);
      checks++;
      if (fault !== exp_f[i]) begin
        errors++;
        $display("FAIL fault_flag@%h: got %b want %b", addrs[i], fault, exp_f[i]);
      end
      checks++;
      if (instr !== exp_i[i]) begin
        errors++;
        $display("FAIL fault_instr@%h: got %h want %h", addrs[i], instr, exp_i[i]);
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] instr;
    logic        fault;
    int          lat;
    do_reset();
    prog(32'h10, 32'hAABBCCDD, 4'hF);
    prog(32'h10, 32'h11223344, 4'b0101);
    fetch(0, 32'h10, instr, fault, lat);
    checks++;
    if (instr !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL byte_enable: got %h want aa22cc44", instr);
    end
    prog(32'h400, 32'hDEADBEEF, 4'hF);
    fetch(0, 32'h0, instr, fault, lat);
    checks++;
    if (instr !== 32'h00100093) begin
      errors++;
      $display("FAIL oob_write_low: got %h want 00100093", instr);
    end
    fetch(0, 32'h3FC, instr, fault, lat);
    checks++;
    if (instr !== 32'h0) begin
      errors++;
      $display("FAIL oob_write_top: got %h want 00000000", instr);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] instr;
    logic        fault;
    int          lat;
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    prog_we = 1'b1; prog_addr = 32'h8; prog_wdata = 32'hCAFEF00D; prog_be = 4'hF;
    @(posedge clk); #1;
    prog_we = 1'b0;
    checks++;
    if (rv[1] !== 1'b1 || ri[1] !== 32'h002081b3) begin
      errors++;
      $display("FAIL same_edge_old: got valid=%b instr=%h want 1 002081b3", rv[1], ri[1]);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    fetch(1, 32'h8, instr, fault, lat);
    checks++;
    if (instr !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL same_edge_new: got %h want cafef00d", instr);
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL same_edge_latency: got %0d want 2", lat);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] instr;
    logic        fault;
    int          lat;
    int          stale;
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (rr[3] !== 1'b0) begin
      errors++;
      $display("FAIL wait_ready: got %b want 0", rr[3]);
    end
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rv[3] !== 1'b0 || rr[3] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got valid=%b ready=%b want 0 1", rv[3], rr[3]);
    end
    #1 rst = 1'b0;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rv[3] !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL stale_resp: got %0d valid cycles want 0", stale);
    end
    fetch(3, 32'h4, instr, fault, lat);
    checks++;
    if (instr !== 32'h00200113) begin
      errors++;
      $display("FAIL mem_retained: got %h want 00200113", instr);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL l4_latency: got %0d want 4", lat);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_faults();
    test_byte_enable();
    test_same_edge();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
